// File: rtl/mpsoc_msi_wb_pkg.sv
// Shared Wishbone definitions for the MSI interconnect: cycle/burst type
// encodings and the arbiter state type.
package mpsoc_msi_wb_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INC     = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR  = 2'b00;
  localparam logic [1:0] BTE_WRAP4   = 2'b01;
  localparam logic [1:0] BTE_WRAP8   = 2'b10;
  localparam logic [1:0] BTE_WRAP16  = 2'b11;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/mpsoc_msi_wb_rr_arbiter.sv
// Combinational round-robin selector: picks the first requester above
// last_grant_i, wrapping around, so the last winner has lowest priority.
module mpsoc_msi_wb_rr_arbiter
  import mpsoc_msi_wb_pkg::*;
#(
  parameter int N  = 2,
  parameter int GW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [GW-1:0] last_grant_i,
  output logic [GW-1:0] grant_o,
  output logic          valid_o
);

  int idx;

  // Scan from the farthest offset down so the nearest requester overwrites last.
  always_comb begin
    grant_o = '0;
    valid_o = 1'b0;
    idx     = 0;
    for (int off = N; off >= 1; off--) begin
      idx = (int'(last_grant_i) + off) % N;
      if (req_i[idx]) begin
        grant_o = GW'(idx);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mpsoc_msi_wb_arbiter.sv
// N-master to 1-slave Wishbone arbiter: round-robin grant held for a whole
// CYC, responses steered to the granted master, stall watchdog raising ERR.
module mpsoc_msi_wb_arbiter
  import mpsoc_msi_wb_pkg::*;
#(
  parameter int DW          = 32,
  parameter int AW          = 32,
  parameter int NUM_MASTERS = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic                                wb_clk_i,
  input  logic                                wb_rst_i,
  input  logic [NUM_MASTERS-1:0][AW-1:0]      wbm_adr_i,
  input  logic [NUM_MASTERS-1:0][DW-1:0]      wbm_dat_i,
  input  logic [NUM_MASTERS-1:0][3:0]         wbm_sel_i,
  input  logic [NUM_MASTERS-1:0]              wbm_we_i,
  input  logic [NUM_MASTERS-1:0]              wbm_cyc_i,
  input  logic [NUM_MASTERS-1:0]              wbm_stb_i,
  input  logic [NUM_MASTERS-1:0][2:0]         wbm_cti_i,
  input  logic [NUM_MASTERS-1:0][1:0]         wbm_bte_i,
  output logic [NUM_MASTERS-1:0][DW-1:0]      wbm_dat_o,
  output logic [NUM_MASTERS-1:0]              wbm_ack_o,
  output logic [NUM_MASTERS-1:0]              wbm_err_o,
  output logic [NUM_MASTERS-1:0]              wbm_rty_o,
  output logic [AW-1:0]                       wbs_adr_o,
  output logic [DW-1:0]                       wbs_dat_o,
  output logic [3:0]                          wbs_sel_o,
  output logic                                wbs_we_o,
  output logic                                wbs_cyc_o,
  output logic                                wbs_stb_o,
  output logic [2:0]                          wbs_cti_o,
  output logic [1:0]                          wbs_bte_o,
  input  logic [DW-1:0]                       wbs_dat_i,
  input  logic                                wbs_ack_i,
  input  logic                                wbs_err_i,
  input  logic                                wbs_rty_i
);

  localparam int GRANT_BITS = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int WDW        = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  arb_state_e              state_q, state_d;
  logic [GRANT_BITS-1:0]   grant_q, grant_d;
  logic [GRANT_BITS-1:0]   last_grant_q, last_grant_d;
  logic [GRANT_BITS-1:0]   rr_grant;
  logic                    rr_valid;
  logic                    busy;
  logic                    gnt_cyc;
  logic                    slv_resp;
  logic                    wd_fire;

  mpsoc_msi_wb_rr_arbiter #(
    .N  (NUM_MASTERS),
    .GW (GRANT_BITS)
  ) u_rr (
    .req_i        (wbm_cyc_i),
    .last_grant_i (last_grant_q),
    .grant_o      (rr_grant),
    .valid_o      (rr_valid)
  );

  assign busy     = (state_q == ARB_BUSY);
  assign gnt_cyc  = wbm_cyc_i[grant_q];
  assign slv_resp = wbs_ack_i | wbs_err_i | wbs_rty_i;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q      <= ARB_IDLE;
      grant_q      <= '0;
      last_grant_q <= GRANT_BITS'(NUM_MASTERS - 1);
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

  // The grant only moves from IDLE, which forces a dead cycle between owners.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    case (state_q)
      ARB_IDLE: begin
        if (rr_valid) begin
          grant_d = rr_grant;
          state_d = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        if (!gnt_cyc) begin
          state_d      = ARB_IDLE;
          last_grant_d = grant_q;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  assign wbs_adr_o = wbm_adr_i[grant_q];
  assign wbs_dat_o = wbm_dat_i[grant_q];
  assign wbs_sel_o = wbm_sel_i[grant_q];
  assign wbs_we_o  = wbm_we_i[grant_q];
  assign wbs_cti_o = wbm_cti_i[grant_q];
  assign wbs_bte_o = wbm_bte_i[grant_q];
  assign wbs_cyc_o = busy & gnt_cyc;
  assign wbs_stb_o = busy & gnt_cyc & wbm_stb_i[grant_q];

  // A real slave response in the firing cycle suppresses the forced error.
  if (TIMEOUT > 0) begin : g_wd
    localparam logic [WDW-1:0] WD_LIMIT = WDW'(TIMEOUT);
    logic [WDW-1:0] wd_cnt_q, wd_cnt_d;

    assign wd_fire = wbs_stb_o & ~slv_resp & (wd_cnt_q == WD_LIMIT);

    always_comb begin
      wd_cnt_d = '0;
      if (wbs_stb_o && !slv_resp && !wd_fire) begin
        wd_cnt_d = wd_cnt_q + 1'b1;
      end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
        wd_cnt_q <= '0;
      end else begin
        wd_cnt_q <= wd_cnt_d;
      end
    end
  end else begin : g_no_wd
    assign wd_fire = 1'b0;
  end

  always_comb begin
    wbm_ack_o = '0;
    wbm_err_o = '0;
    wbm_rty_o = '0;
    wbm_dat_o = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      wbm_dat_o[i] = wbs_dat_i;
      if (busy && (GRANT_BITS'(i) == grant_q)) begin
        wbm_ack_o[i] = wbs_ack_i;
        wbm_rty_o[i] = wbs_rty_i;
        wbm_err_o[i] = wbs_err_i | wd_fire;
      end
    end
  end

endmodule
